spi_slave_9952: RTL and testbench

SPI_SLAVE_9952 -- requirements
Module: spi_slave_9952

---
 rtl/spi_slave_9952.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_spi_slave_9952.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_9952.sv
// SPI register slave: 8-bit instruction (R/W + 5-bit address) followed by a
// register-sized data phase. Writes land in buffer registers; an io_update
// rising edge copies every buffer register into its active register.
module spi_slave_9952 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        n_cs,
  input  logic        sclk,
  input  logic        sdio_i,
  output logic        sdio_o,
  output logic        sdio_oe,
  input  logic        io_update,
  output logic [31:0] cfr1,
  output logic [23:0] cfr2,
  output logic [15:0] asf,
  output logic [7:0]  arr,
  output logic [31:0] ftw,
  output logic [15:0] pow,
  output logic        wr_done,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam logic [23:0] CFR2_RST = 24'h000018;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] ncs_sync, sclk_sync, sdio_sync, iou_sync;
  logic ncs_s, sclk_s, sdio_s, iou_s;
  logic ncs_d, sclk_d, iou_d;
  logic ncs_rise, ncs_fall, sclk_rise, sclk_fall, iou_rise;

  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [1:0]  last_byte;
  logic [4:0]  addr_q;
  logic        addr_ok;
  logic [6:0]  instr_sr;
  logic [30:0] wd_sr;
  logic [31:0] rd_sr;

  logic [7:0]  instr_word;
  logic [31:0] wr_word;
  logic        instr_done;
  logic        data_last;
  logic        wr_commit;
  logic [4:0]  new_addr;
  logic        new_ok;
  logic [1:0]  new_last;
  logic [31:0] rd_load;

  logic [31:0] b_cfr1, b_cfr1_nx;
  logic [23:0] b_cfr2, b_cfr2_nx;
  logic [15:0] b_asf,  b_asf_nx;
  logic [7:0]  b_arr,  b_arr_nx;
  logic [31:0] b_ftw,  b_ftw_nx;
  logic [15:0] b_pow,  b_pow_nx;

  // Input synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_sync  <= '1;
      sclk_sync <= '0;
      sdio_sync <= '0;
      iou_sync  <= '0;
      ncs_d     <= 1'b1;
      sclk_d    <= 1'b0;
      iou_d     <= 1'b0;
    end else begin
      ncs_sync[0]  <= n_cs;
      sclk_sync[0] <= sclk;
      sdio_sync[0] <= sdio_i;
      iou_sync[0]  <= io_update;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        ncs_sync[i]  <= ncs_sync[i-1];
        sclk_sync[i] <= sclk_sync[i-1];
        sdio_sync[i] <= sdio_sync[i-1];
        iou_sync[i]  <= iou_sync[i-1];
      end
      ncs_d  <= ncs_s;
      sclk_d <= sclk_s;
      iou_d  <= iou_s;
    end
  end

  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdio_s    = sdio_sync[SYNC_STAGES-1];
  assign iou_s     = iou_sync[SYNC_STAGES-1];
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign iou_rise  = iou_s & ~iou_d;

  assign instr_word = {instr_sr, sdio_s};
  assign wr_word    = {wd_sr, sdio_s};
  assign instr_done = (state == INSTR) && sclk_rise && (bit_cnt == 3'd7);
  assign data_last  = sclk_rise && (bit_cnt == 3'd7) && (byte_cnt == last_byte);
  assign wr_commit  = (state == WDATA) && data_last && addr_ok && !ncs_rise;
  assign new_addr   = instr_word[4:0];

  // Instruction decode: validity and last byte index of the data phase.
  always_comb begin
    new_ok   = 1'b1;
    new_last = 2'd0;
    case (new_addr)
      5'h00:   new_last = 2'd3;
      5'h01:   new_last = 2'd2;
      5'h02:   new_last = 2'd1;
      5'h03:   new_last = 2'd0;
      5'h04:   new_last = 2'd3;
      5'h05:   new_last = 2'd1;
      default: new_ok   = 1'b0;
    endcase
  end

  // Buffer value for a read, left-aligned so the MSB leaves first.
  always_comb begin
    rd_load = '0;
    case (new_addr)
      5'h00:   rd_load = b_cfr1;
      5'h01:   rd_load = {b_cfr2, 8'h00};
      5'h02:   rd_load = {b_asf, 16'h0000};
      5'h03:   rd_load = {b_arr, 24'h000000};
      5'h04:   rd_load = b_ftw;
      5'h05:   rd_load = {b_pow, 16'h0000};
      default: rd_load = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; chip-select release overrides everything.
  always_comb begin
    state_nx = state;
    if (ncs_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (ncs_fall)   state_nx = INSTR;
        INSTR:   if (instr_done) state_nx = instr_word[7] ? RDATA : WDATA;
        WDATA:   if (data_last)  state_nx = INSTR;
        RDATA:   if (data_last)  state_nx = INSTR;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Shift registers, counters, read output and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      last_byte <= '0;
      addr_q    <= '0;
      addr_ok   <= 1'b0;
      instr_sr  <= '0;
      wd_sr     <= '0;
      rd_sr     <= '0;
      sdio_o    <= 1'b0;
      sdio_oe   <= 1'b0;
      wr_done   <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      wr_done  <= wr_commit;
      addr_err <= instr_done && !new_ok && !ncs_rise;
      if (ncs_rise) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        sdio_oe  <= 1'b0;
        sdio_o   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
          INSTR: begin
            if (sclk_rise) begin
              instr_sr <= instr_word[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr_q    <= new_addr;
                addr_ok   <= new_ok;
                last_byte <= new_last;
                byte_cnt  <= '0;
                wd_sr     <= '0;
                if (instr_word[7]) rd_sr <= rd_load;
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              wd_sr   <= wr_word[30:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (data_last)            byte_cnt <= '0;
              else if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + 2'd1;
            end
          end
          RDATA: begin
            // Each falling edge presents the next bit; the first one also
            // turns the driver on.
            if (sclk_fall) begin
              sdio_oe <= 1'b1;
              sdio_o  <= rd_sr[31];
              rd_sr   <= {rd_sr[30:0], 1'b0};
            end
            if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (data_last) begin
                byte_cnt <= '0;
                sdio_oe  <= 1'b0;
                sdio_o   <= 1'b0;
              end else if (bit_cnt == 3'd7) begin
                byte_cnt <= byte_cnt + 2'd1;
              end
            end
          end
          default: begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Buffer next values: a completed write replaces the addressed register.
  always_comb begin
    b_cfr1_nx = b_cfr1;
    b_cfr2_nx = b_cfr2;
    b_asf_nx  = b_asf;
    b_arr_nx  = b_arr;
    b_ftw_nx  = b_ftw;
    b_pow_nx  = b_pow;
    if (wr_commit) begin
      case (addr_q)
        5'h00:   b_cfr1_nx = wr_word;
        5'h01:   b_cfr2_nx = wr_word[23:0];
        5'h02:   b_asf_nx  = wr_word[15:0];
        5'h03:   b_arr_nx  = wr_word[7:0];
        5'h04:   b_ftw_nx  = wr_word;
        5'h05:   b_pow_nx  = wr_word[15:0];
        default: ;
      endcase
    end
  end

  // Buffer and active registers. Active copies take the buffer next value
  // so a write completing on the io_update clock is transferred at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_cfr1 <= '0;
      b_cfr2 <= CFR2_RST;
      b_asf  <= '0;
      b_arr  <= '0;
      b_ftw  <= '0;
      b_pow  <= '0;
      cfr1   <= '0;
      cfr2   <= CFR2_RST;
      asf    <= '0;
      arr    <= '0;
      ftw    <= '0;
      pow    <= '0;
    end else begin
      b_cfr1 <= b_cfr1_nx;
      b_cfr2 <= b_cfr2_nx;
      b_asf  <= b_asf_nx;
      b_arr  <= b_arr_nx;
      b_ftw  <= b_ftw_nx;
      b_pow  <= b_pow_nx;
      if (iou_rise) begin
        cfr1 <= b_cfr1_nx;
        cfr2 <= b_cfr2_nx;
        asf  <= b_asf_nx;
        arr  <= b_arr_nx;
        ftw  <= b_ftw_nx;
        pow  <= b_pow_nx;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_9952.sv
// Testbench for spi_slave_9952: randomized SPI frames checked against a
// register-map model (buffer/active arrays indexed by address).
module tb_spi_slave_9952;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_cs;
  logic        sclk;
  logic        sdio_i;
  logic        sdio_o;
  logic        sdio_oe;
  logic        io_update;
  logic [31:0] cfr1;
  logic [23:0] cfr2;
  logic [15:0] asf;
  logic [7:0]  arr;
  logic [31:0] ftw;
  logic [15:0] pow;
  logic        wr_done;
  logic        addr_err;

  int total = 0;
  int bad   = 0;
  int wr_seen  = 0;
  int err_seen = 0;

  logic [31:0] buf_m [6];
  logic [31:0] act_m [6];

  spi_slave_9952 #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .n_cs(n_cs), .sclk(sclk), .sdio_i(sdio_i),
    .sdio_o(sdio_o), .sdio_oe(sdio_oe), .io_update(io_update),
    .cfr1(cfr1), .cfr2(cfr2), .asf(asf), .arr(arr), .ftw(ftw), .pow(pow),
    .wr_done(wr_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Pulse counters for the one-clk status outputs.
  always @(negedge clk) begin
    if (wr_done === 1'b1)  wr_seen++;
    if (addr_err === 1'b1) err_seen++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int nb(input logic [4:0] a);
    case (a)
      5'd0: return 4;
      5'd1: return 3;
      5'd2: return 2;
      5'd3: return 1;
      5'd4: return 4;
      5'd5: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input logic [4:0] a);
    case (nb(a))
      1: return 32'h000000FF;
      2: return 32'h0000FFFF;
      3: return 32'h00FFFFFF;
      default: return 32'hFFFFFFFF;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) buf_m[i] = 32'h0;
    buf_m[1] = 32'h00000018;
    for (int i = 0; i < 6; i++) act_m[i] = buf_m[i];
  endfunction

  function automatic void model_write(input logic [7:0] ins, input logic [31:0] data);
    if (!ins[7] && ins[4:0] < 5'd6) buf_m[int'(ins[4:0])] = data & mask_of(ins[4:0]);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a < 5'd6) return buf_m[int'(a)];
    return 32'h0;
  endfunction

  function automatic logic [127:0] dut_act();
    return {cfr1, cfr2, asf, arr, ftw, pow};
  endfunction

  function automatic logic [127:0] model_act();
    return {act_m[0], act_m[1][23:0], act_m[2][15:0], act_m[3][7:0], act_m[4], act_m[5][15:0]};
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic bit_xfer(input logic b, input logic io_edge, output logic so, output logic oe);
    sdio_i = b;
    repeat ($urandom_range(4, 7)) @(negedge clk);
    so = sdio_o;
    oe = sdio_oe;
    sclk = 1'b1;
    if (io_edge) io_update = 1'b1;
    repeat ($urandom_range(4, 7)) @(negedge clk);
    sclk = 1'b0;
    io_update = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] ins, input logic [31:0] data, input logic io_last,
                      output logic [31:0] rd, output int oe_cnt);
    int n;
    logic so, oe;
    n = nb(ins[4:0]);
    rd = 32'h0;
    oe_cnt = 0;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(ins[i], 1'b0, so, oe);
      if (oe) oe_cnt++;
    end
    for (int i = n * 8 - 1; i >= 0; i--) begin
      bit_xfer(ins[7] ? 1'b0 : data[i], io_last && (i == 0), so, oe);
      if (oe) oe_cnt++;
      rd = {rd[30:0], so};
    end
  endtask

  task automatic cs_low();
    n_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (3) @(negedge clk);
    n_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_io();
    io_update = 1'b1;
    repeat (4) @(negedge clk);
    io_update = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 6; i++) act_m[i] = buf_m[i];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++; if (dut_act() !== model_act()) begin bad++; $display("FAIL reset_regs: got %h want %h", dut_act(), model_act()); end
    total++; if (sdio_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", sdio_oe); end
    total++; if (sdio_o !== 1'b0) begin bad++; $display("FAIL reset_sdio_o: got %b want 0", sdio_o); end
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL reset_wr_done: got %b want 0", wr_done); end
    total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
  endtask

  task automatic test_ftw_write();
    logic [31:0] rd; int oe; int w0;
    w0 = wr_seen;
    cs_low();
    xfer(8'h04, 32'h12345678, 1'b0, rd, oe);
    model_write(8'h04, 32'h12345678);
    cs_high();
    total++; if (wr_seen - w0 != 1) begin bad++; $display("FAIL ftw_wr_done: got %0d pulses want 1", wr_seen - w0); end
    total++; if (oe != 0) begin bad++; $display("FAIL ftw_oe: got %0d want 0", oe); end
    total++; if (ftw !== 32'h0) begin bad++; $display("FAIL ftw_hold: got %h want 00000000", ftw); end
    pulse_io();
    total++; if (ftw !== 32'h12345678) begin bad++; $display("FAIL ftw_update: got %h want 12345678", ftw); end
    total++; if (dut_act() !== model_act()) begin bad++; $display("FAIL ftw_regs: got %h want %h", dut_act(), model_act()); end
  endtask

  task automatic test_pow_readback();
    logic [31:0] rd; int oe;
    cs_low();
    xfer(8'h05, 32'h0000ABCD, 1'b0, rd, oe);
    model_write(8'h05, 32'h0000ABCD);
    cs_high();
    cs_low();
    xfer(8'h85, 32'h0, 1'b0, rd, oe);
    cs_high();
    total++; if (rd !== model_read(5'h05)) begin bad++; $display("FAIL pow_read: got %h want %h", rd, model_read(5'h05)); end
    total++; if (oe != 16) begin bad++; $display("FAIL pow_oe_cycles: got %0d want 16", oe); end
    total++; if (pow !== 16'h0) begin bad++; $display("FAIL pow_hold: got %h want 0000", pow); end
  endtask

  task automatic test_partial_write();
    logic [31:0] rd; int oe; int w0;
    logic [15:0] bits; logic so, oeb;
    bits = 16'h023F;
    w0 = wr_seen;
    cs_low();
    for (int i = 15; i >= 0; i--) bit_xfer(bits[i], 1'b0, so, oeb);
    cs_high();
    total++; if (wr_seen != w0) begin bad++; $display("FAIL partial_wr_done: got %0d pulses want 0", wr_seen - w0); end
    total++; if (sdio_oe !== 1'b0) begin bad++; $display("FAIL partial_oe: got %b want 0", sdio_oe); end
    cs_low();
    xfer(8'h82, 32'h0, 1'b0, rd, oe);
    cs_high();
    total++; if (rd !== model_read(5'h02)) begin bad++; $display("FAIL partial_asf_buf: got %h want %h", rd, model_read(5'h02)); end
    total++; if (oe != 16) begin bad++; $display("FAIL partial_next_frame_oe: got %0d want 16", oe); end
    pulse_io();
    total++; if (asf !== 16'h0) begin bad++; $display("FAIL partial_asf: got %h want 0000", asf); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2; int oe; int w0;
    w0 = wr_seen;
    cs_low();
    xfer(8'h03, 32'h0000007F, 1'b0, rd1, oe);
    xfer(8'h00, 32'h11223344, 1'b0, rd1, oe);
    cs_high();
    model_write(8'h03, 32'h0000007F);
    model_write(8'h00, 32'h11223344);
    total++; if (wr_seen - w0 != 2) begin bad++; $display("FAIL b2b_wr_done: got %0d pulses want 2", wr_seen - w0); end
    cs_low();
    xfer(8'h83, 32'h0, 1'b0, rd1, oe);
    xfer(8'h80, 32'h0, 1'b0, rd2, oe);
    cs_high();
    total++; if (rd1 !== 32'h7F) begin bad++; $display("FAIL b2b_arr_buf: got %h want 0000007f", rd1); end
    total++; if (rd2 !== 32'h11223344) begin bad++; $display("FAIL b2b_cfr1_buf: got %h want 11223344", rd2); end
    pulse_io();
    total++; if (dut_act() !== model_act()) begin bad++; $display("FAIL b2b_regs: got %h want %h", dut_act(), model_act()); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] rd; int oe; int e0;
    e0 = err_seen;
    cs_low();
    xfer(8'h1A, 32'h000000FF, 1'b0, rd, oe);
    cs_high();
    cs_low();
    xfer(8'h9A, 32'h0, 1'b0, rd, oe);
    cs_high();
    total++; if (err_seen - e0 != 2) begin bad++; $display("FAIL bad_addr_err: got %0d pulses want 2", err_seen - e0); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL bad_addr_read: got %h want 00000000", rd); end
    total++; if (oe != 8) begin bad++; $display("FAIL bad_addr_oe: got %0d want 8", oe); end
    pulse_io();
    total++; if (dut_act() !== model_act()) begin bad++; $display("FAIL bad_addr_regs: got %h want %h", dut_act(), model_act()); end
  endtask

  task automatic test_update_collision();
    logic [31:0] rd; int oe; logic [31:0] d;
    d = {16'h0, 16'($urandom_range(1, 16'hFFFF))};
    cs_low();
    xfer(8'h05, d, 1'b1, rd, oe);
    cs_high();
    model_write(8'h05, d);
    for (int i = 0; i < 6; i++) act_m[i] = buf_m[i];
    total++; if (pow !== d[15:0]) begin bad++; $display("FAIL collide_pow: got %h want %h", pow, d[15:0]); end
    total++; if (dut_act() !== model_act()) begin bad++; $display("FAIL collide_regs: got %h want %h", dut_act(), model_act()); end
  endtask

  task automatic test_rst_midread();
    logic [15:0] bits; logic so, oeb; logic [31:0] rd; int oe; int w0; logic [31:0] d;
    bits = 16'h8100;
    cs_low();
    for (int i = 15; i >= 3; i--) bit_xfer(bits[i], 1'b0, so, oeb);
    total++; if (oeb !== 1'b1) begin bad++; $display("FAIL rst_pre_oe: got %b want 1", oeb); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (sdio_oe !== 1'b0) begin bad++; $display("FAIL rst_oe_drop: got %b want 0", sdio_oe); end
    @(negedge clk);
    n_cs = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    total++; if (cfr2 !== 24'h000018) begin bad++; $display("FAIL rst_cfr2: got %h want 000018", cfr2); end
    total++; if (dut_act() !== model_act()) begin bad++; $display("FAIL rst_regs: got %h want %h", dut_act(), model_act()); end
    d = {8'h0, 24'($urandom)};
    w0 = wr_seen;
    cs_low();
    xfer(8'h01, d, 1'b0, rd, oe);
    cs_high();
    model_write(8'h01, d);
    total++; if (wr_seen - w0 != 1) begin bad++; $display("FAIL rst_next_wr_done: got %0d pulses want 1", wr_seen - w0); end
    pulse_io();
    total++; if (cfr2 !== d[23:0]) begin bad++; $display("FAIL rst_next_cfr2: got %h want %h", cfr2, d[23:0]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, exp_rd; int oe; int k, w0, e0, exp_w, exp_e;
    logic [4:0] a; logic rw; logic [7:0] ins;
    for (int f = 0; f < 20; f++) begin
      w0 = wr_seen; e0 = err_seen; exp_w = 0; exp_e = 0;
      k = int'($urandom_range(1, 3));
      cs_low();
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(0, 7) == 0) a = 5'($urandom_range(6, 31));
        else                           a = 5'($urandom_range(0, 5));
        rw  = 1'($urandom_range(0, 1));
        ins = {rw, 2'($urandom_range(0, 3)), a};
        d   = $urandom;
        exp_rd = model_read(a);
        xfer(ins, d, 1'b0, rd, oe);
        if (a >= 5'd6) exp_e++;
        if (rw) begin
          total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand_read f%0d a%0h: got %h want %h", f, a, rd, exp_rd); end
          total++; if (oe != nb(a) * 8) begin bad++; $display("FAIL rand_oe f%0d: got %0d want %0d", f, oe, nb(a) * 8); end
        end else begin
          model_write(ins, d);
          if (a < 5'd6) exp_w++;
          total++; if (oe != 0) begin bad++; $display("FAIL rand_wr_oe f%0d: got %0d want 0", f, oe); end
        end
      end
      cs_high();
      total++; if (wr_seen - w0 != exp_w) begin bad++; $display("FAIL rand_wr_done f%0d: got %0d want %0d", f, wr_seen - w0, exp_w); end
      total++; if (err_seen - e0 != exp_e) begin bad++; $display("FAIL rand_addr_err f%0d: got %0d want %0d", f, err_seen - e0, exp_e); end
      if ($urandom_range(0, 1) == 1) begin
        pulse_io();
        total++; if (dut_act() !== model_act()) begin bad++; $display("FAIL rand_regs f%0d: got %h want %h", f, dut_act(), model_act()); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    n_cs = 1'b1;
    sclk = 1'b0;
    sdio_i = 1'b0;
    io_update = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_ftw_write();
    test_pow_readback();
    test_partial_write();
    test_back_to_back();
    test_bad_addr();
    test_update_collision();
    test_rst_midread();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
